// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the data-memory responder: the funct3 encodings
// used for load/store width and sign, and the responder state enum.
// No ports (package).
// ---------------------------------------------------------------------------
package mem_pkg;

   // funct3 encodings for loads and stores (stores only use B/H/W)
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Responder FSM states
   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_e;

endpackage

// File: rtl/mem_lane_fmt.sv
// ---------------------------------------------------------------------------
// mem_lane_fmt
// Combinational byte-lane formatter between the datapath and a 32-bit
// word-organised RAM. Produces byte enables and lane-replicated store data
// for stores, and the shifted, sign/zero-extended result for loads.
// Ports:
//   f3_i        funct3 of the access (width / sign)
//   addr_lo_i   byte offset within the word (addr[1:0])
//   wdata_i     store data, LSB-aligned
//   rword_i     raw 32-bit word read from the RAM
//   be_o        byte-lane write enables (0 for an unknown f3)
//   wdata_o     store data replicated onto every candidate lane
//   rdata_o     load result, shifted to bit 0 and extended
//   align_err_o half access on an odd address or word access off a word
// ---------------------------------------------------------------------------
module mem_lane_fmt
   import mem_pkg::*;
(
   input  logic [2:0]  f3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o,
   output logic        align_err_o
);

   logic [31:0] shifted;

   // Store data is replicated across all lanes so the byte enables alone
   // pick which lanes change. Load data is shifted down by the byte offset
   // first, which puts both the byte and the halfword case at bit 0.
   always_comb begin
      be_o        = 4'b0000;
      wdata_o     = 32'd0;
      rdata_o     = 32'd0;
      align_err_o = 1'b0;
      shifted     = rword_i >> {addr_lo_i, 3'b000};
      case (f3_i)
         F3_B, F3_BU: begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
            if (f3_i == F3_B) begin
               rdata_o = {{24{shifted[7]}}, shifted[7:0]};
            end else begin
               rdata_o = {24'd0, shifted[7:0]};
            end
         end
         F3_H, F3_HU: begin
            align_err_o = addr_lo_i[0];
            be_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wdata_o     = {2{wdata_i[15:0]}};
            if (f3_i == F3_H) begin
               rdata_o = {{16{shifted[15]}}, shifted[15:0]};
            end else begin
               rdata_o = {16'd0, shifted[15:0]};
            end
         end
         F3_W: begin
            align_err_o = (addr_lo_i != 2'b00);
            be_o        = 4'b1111;
            wdata_o     = wdata_i;
            rdata_o     = rword_i;
         end
         default: begin
            be_o = 4'b0000;
         end
      endcase
   end

endmodule

// File: rtl/data_mem_resp.sv
// ---------------------------------------------------------------------------
// data_mem_resp
// Responder end of the core's data-memory interface. Accepts one load or
// store, waits WAIT_CYCLES cycles, executes it against an internal RAM and
// emits a one-cycle response. rsp_rdata / rsp_err hold until the next
// response.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid / req_ready request handshake (taken when both high at edge)
//   req_we, req_f3        store flag and funct3 width/sign
//   req_addr, req_wdata   byte address and LSB-aligned store data
//   rsp_valid             one-cycle response pulse
//   rsp_rdata, rsp_err    load result (0 for stores/errors) and error flag
// ---------------------------------------------------------------------------
module data_mem_resp
   import mem_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_f3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int         IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic [31:0] mem_q [DEPTH_WORDS];

   logic        accept;
   logic        go_resp;
   logic        cur_we;
   logic [2:0]  cur_f3;
   logic [31:0] cur_addr;
   logic [31:0] cur_wdata;
   logic [IDX_W-1:0] cur_idx;
   logic        f3_ok;
   logic        range_err;
   logic        access_err;
   logic [3:0]  fmt_be;
   logic [31:0] fmt_wdata;
   logic [31:0] fmt_rdata;
   logic        fmt_align_err;

   assign accept    = req_valid && (state_q == IDLE);
   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

   // With zero wait states the access executes on the accept edge itself,
   // before the latch is loaded, so the live request is used while IDLE.
   assign cur_we    = (state_q == IDLE) ? req_we    : we_q;
   assign cur_f3    = (state_q == IDLE) ? req_f3    : f3_q;
   assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
   assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
   assign cur_idx   = cur_addr[IDX_W+1:2];

   // Error classification: illegal f3 for the direction, misalignment,
   // nonzero undecoded upper bits, or a word index past the end of the RAM.
   assign f3_ok = cur_we ? (cur_f3 inside {F3_B, F3_H, F3_W})
                         : (cur_f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
   assign range_err  = ((cur_addr >> ADDR_W) != 32'd0) ||
                       (32'(cur_addr[ADDR_W-1:2]) >= 32'(DEPTH_WORDS));
   assign access_err = !f3_ok || fmt_align_err || range_err;

   mem_lane_fmt u_fmt (
      .f3_i        (cur_f3),
      .addr_lo_i   (cur_addr[1:0]),
      .wdata_i     (cur_wdata),
      .rword_i     (mem_q[cur_idx]),
      .be_o        (fmt_be),
      .wdata_o     (fmt_wdata),
      .rdata_o     (fmt_rdata),
      .align_err_o (fmt_align_err)
   );

   // Next-state logic: WAIT runs for WAIT_CYCLES cycles counting down to 0,
   // and RESP always lasts exactly one cycle since there is no backpressure.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (WAIT_CYCLES == 0) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   assign go_resp = (state_d == RESP) && (state_q != RESP);

   // State, request latch and response registers. The response data is
   // captured on the edge entering RESP and then held until the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_f3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         if (go_resp) begin
            err_q   <= access_err;
            rdata_q <= (access_err || cur_we) ? 32'd0 : fmt_rdata;
         end
      end
   end

   // RAM write port, not reset. rst_n gates the commit so an access caught
   // by reset never lands in the array.
   always_ff @(posedge clk) begin
      if (rst_n && go_resp && cur_we && !access_err) begin
         for (int b = 0; b < 4; b++) begin
            if (fmt_be[b]) begin
               mem_q[cur_idx][8*b +: 8] <= fmt_wdata[8*b +: 8];
            end
         end
      end
   end

endmodule
